// File: rtl/sensor_cmd_pkg.sv
// Shared codes for the sensor read path: command codes, parser error codes,
// the decoder's own error code, and the parser's state encoding.
package sensor_cmd_pkg;

  typedef enum logic [7:0] {
    CMD_STATUS     = 8'h00,
    CMD_TEMP_INT   = 8'h01,
    CMD_TEMP_FLOAT = 8'h02,
    CMD_HUM_INT    = 8'h03,
    CMD_HUM_FLOAT  = 8'h04,
    CMD_TEMP_CONT  = 8'h05,
    CMD_HUM_CONT   = 8'h06,
    CMD_STOP_TEMP  = 8'h07,
    CMD_STOP_HUM   = 8'h08
  } cmd_e;

  typedef enum logic [7:0] {
    ERR_BUSY          = 8'hE1,
    ERR_BAD_ADDR      = 8'hE2,
    ERR_NOT_STREAMING = 8'hE3,
    ERR_TIMEOUT       = 8'hE4,
    ERR_DECODER       = 8'hEC
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CMD = 3'd1,
    S_BUSY     = 3'd2,
    S_STREAM   = 3'd3,
    S_STOPPING = 3'd4
  } parser_state_e;

  // Continuous-read start commands open a streaming session.
  function automatic logic is_stream_cmd(input logic [7:0] code);
    return (code == CMD_TEMP_CONT) || (code == CMD_HUM_CONT);
  endfunction

  // Stop commands are only meaningful inside a streaming session.
  function automatic logic is_stop_cmd(input logic [7:0] code);
    return (code == CMD_STOP_TEMP) || (code == CMD_STOP_HUM);
  endfunction

endpackage

// File: rtl/command_parser_if.sv
// Byte input, decoder handshake and error report bundle of command_parser.
// slave: the parser itself; master: whatever drives bytes and finished.
interface command_parser_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        finished;
  logic        enable;
  logic [31:0] device_selector;
  logic [7:0]  request;
  logic        streaming;
  logic        error_valid;
  logic [7:0]  error_code;

  modport slave (
    input  rx_data, rx_done, finished,
    output enable, device_selector, request, streaming, error_valid, error_code
  );

  modport master (
    output rx_data, rx_done, finished,
    input  enable, device_selector, request, streaming, error_valid, error_code
  );
endinterface

// File: rtl/byte_pair_assembler.sv
// Collects {address, command} byte pairs. The first byte is latched as the
// address; the next byte completes the pair (pair_vld_o, command = rx_data_i).
// If no second byte arrives within BYTE_TIMEOUT cycles, timeout_o strobes and
// the half-pair is dropped. A byte in the expiry cycle still completes the pair.
module byte_pair_assembler #(
  parameter int BYTE_TIMEOUT = 5_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arm_i,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic [7:0] addr_o,
  output logic       pair_vld_o,
  output logic       timeout_o
);

  localparam int CNT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BYTE_TIMEOUT);

  logic             have_addr_q, have_addr_d;
  logic [7:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  assign expired    = (cnt_q == CNT_MAX);
  assign addr_o     = addr_q;
  assign pair_vld_o = arm_i & have_addr_q & rx_done_i;
  assign timeout_o  = arm_i & have_addr_q & ~rx_done_i & expired;

  // Next-state: disarm clears, a byte toggles address/command phase, the
  // counter runs only while waiting for a command byte and stops at the limit.
  always_comb begin
    have_addr_d = have_addr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    if (!arm_i) begin
      have_addr_d = 1'b0;
      cnt_d       = '0;
    end else if (rx_done_i) begin
      cnt_d = '0;
      if (!have_addr_q) begin
        addr_d      = rx_data_i;
        have_addr_d = 1'b1;
      end else begin
        have_addr_d = 1'b0;
      end
    end else if (have_addr_q) begin
      if (expired) have_addr_d = 1'b0;
      else         cnt_d       = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      have_addr_q <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      have_addr_q <= have_addr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/command_parser.sv
// Front end of the sensor read path: validates {address, command} pairs,
// starts the decoder, keeps one transaction outstanding (including
// continuous-read sessions) and reports rejected commands.
module command_parser
  import sensor_cmd_pkg::*;
#(
  parameter int NUM_DEVICES  = 32,
  parameter int BYTE_TIMEOUT = 5_000_000
) (
  input logic              clock,
  input logic              reset_n,
  command_parser_if.slave  bus
);

  parser_state_e state_q;
  logic          enable_q;
  logic [31:0]   dev_sel_q;
  logic [7:0]    request_q;
  logic          streaming_q;
  logic          err_vld_q;
  logic [7:0]    err_code_q;
  logic [7:0]    stream_addr_q;

  logic          asm_arm;
  logic          pair_vld;
  logic          timeout;
  logic [7:0]    pair_addr;

  // Pairs are only assembled when no transaction is outstanding or a stream
  // is open; bytes in BUSY/STOPPING are rejected by the FSM instead.
  assign asm_arm = (state_q == S_IDLE) || (state_q == S_WAIT_CMD) ||
                   (state_q == S_STREAM);

  byte_pair_assembler #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .arm_i      (asm_arm),
    .rx_done_i  (bus.rx_done),
    .rx_data_i  (bus.rx_data),
    .addr_o     (pair_addr),
    .pair_vld_o (pair_vld),
    .timeout_o  (timeout)
  );

  assign bus.enable          = enable_q;
  assign bus.device_selector = dev_sel_q;
  assign bus.request         = request_q;
  assign bus.streaming       = streaming_q;
  assign bus.error_valid     = err_vld_q;
  assign bus.error_code      = err_code_q;

  // Control FSM with registered outputs; enable and error_valid are one-cycle strobes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      enable_q      <= 1'b0;
      dev_sel_q     <= '0;
      request_q     <= '0;
      streaming_q   <= 1'b0;
      err_vld_q     <= 1'b0;
      err_code_q    <= '0;
      stream_addr_q <= '0;
    end else begin
      enable_q  <= 1'b0;
      err_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_done) state_q <= S_WAIT_CMD;
        end
        S_WAIT_CMD: begin
          if (pair_vld) begin
            if (32'(pair_addr) >= 32'(NUM_DEVICES)) begin
              err_vld_q  <= 1'b1;
              err_code_q <= ERR_BAD_ADDR;
              state_q    <= S_IDLE;
            end else if (is_stop_cmd(bus.rx_data)) begin
              err_vld_q  <= 1'b1;
              err_code_q <= ERR_NOT_STREAMING;
              state_q    <= S_IDLE;
            end else begin
              // Codes above the known set are forwarded; the decoder rejects them.
              dev_sel_q     <= 32'(1) << pair_addr[4:0];
              request_q     <= bus.rx_data;
              enable_q      <= 1'b1;
              stream_addr_q <= pair_addr;
              if (is_stream_cmd(bus.rx_data)) begin
                streaming_q <= 1'b1;
                state_q     <= S_STREAM;
              end else begin
                state_q <= S_BUSY;
              end
            end
          end else if (timeout) begin
            err_vld_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_IDLE;
          end
        end
        S_BUSY: begin
          // finished wins over a coincident byte; that byte is still rejected.
          if (bus.finished) state_q <= S_IDLE;
          if (bus.rx_done) begin
            err_vld_q  <= 1'b1;
            err_code_q <= ERR_BUSY;
          end
        end
        S_STREAM: begin
          // Only a stop for the streaming device ends the session, silently.
          if (pair_vld) begin
            if ((pair_addr == stream_addr_q) && is_stop_cmd(bus.rx_data)) begin
              request_q <= bus.rx_data;
              state_q   <= S_STOPPING;
            end else begin
              err_vld_q  <= 1'b1;
              err_code_q <= ERR_BUSY;
            end
          end else if (timeout) begin
            err_vld_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        S_STOPPING: begin
          if (bus.finished) begin
            streaming_q <= 1'b0;
            state_q     <= S_IDLE;
          end
          if (bus.rx_done) begin
            err_vld_q  <= 1'b1;
            err_code_q <= ERR_BUSY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_parser.sv
// Bench for command_parser: directed scenarios followed by random traffic.
module tb_command_parser;

  localparam int TO   = 40;
  localparam int NDEV = 32;

  localparam int SS_IDLE   = 0;
  localparam int SS_BUSY   = 1;
  localparam int SS_STREAM = 2;
  localparam int SS_STOP   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  command_parser_if bus();

  command_parser #(
    .NUM_DEVICES (NDEV),
    .BYTE_TIMEOUT(TO)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  typedef enum int {EV_ENA, EV_ERR, EV_REQ, EV_STR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] a;
    logic [7:0]  b;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         sess   = SS_IDLE;
  logic [7:0] sa     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [31:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [31:0] a, input logic [7:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=%h/%h expected=nothing", k.name(), a, b);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    check({"event_", k.name(), "_value"}, a, e.a);
    if (k == EV_ENA) check("enable_request", 32'(b), 32'(e.b));
  endtask

  // Output monitor
  logic [7:0]  prev_req = '0;
  logic [31:0] prev_dev = '0;
  logic        prev_str = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.enable)      observe(EV_ENA, bus.device_selector, bus.request);
      if (bus.error_valid) observe(EV_ERR, 32'(bus.error_code), 8'h00);
      if (!bus.enable && bus.request != prev_req) observe(EV_REQ, 32'(bus.request), 8'h00);
      if (!bus.enable && bus.device_selector != prev_dev) begin
        checks++;
        errors++;
        $display("FAIL device_selector_hold actual=%h expected=%h", bus.device_selector, prev_dev);
      end
      if (bus.streaming != prev_str) observe(EV_STR, 32'(bus.streaming), 8'h00);
    end
    prev_req = bus.request;
    prev_dev = bus.device_selector;
    prev_str = bus.streaming;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit fin = 1'b0);
    bus.rx_data  = b;
    bus.rx_done  = 1'b1;
    bus.finished = fin;
    tick();
    bus.rx_done  = 1'b0;
    bus.finished = 1'b0;
  endtask

  // Reference behaviour for one {address, command} pair.
  task automatic do_pair(input logic [7:0] a, input logic [7:0] c, input int gap);
    if (sess == SS_BUSY || sess == SS_STOP) begin
      push(EV_ERR, 32'hE1, 8'h00);
      drive_byte(a);
      repeat (gap) tick();
      push(EV_ERR, 32'hE1, 8'h00);
      drive_byte(c);
      return;
    end
    drive_byte(a);
    repeat (gap) tick();
    if (sess == SS_IDLE) begin
      if (a >= NDEV) push(EV_ERR, 32'hE2, 8'h00);
      else if (c == 8'h07 || c == 8'h08) push(EV_ERR, 32'hE3, 8'h00);
      else begin
        push(EV_ENA, 32'd1 << a, c);
        if (c == 8'h05 || c == 8'h06) begin
          push(EV_STR, 32'd1, 8'h00);
          sess = SS_STREAM;
          sa   = a;
        end else begin
          sess = SS_BUSY;
        end
      end
    end else begin
      if (a == sa && (c == 8'h07 || c == 8'h08)) begin
        push(EV_REQ, 32'(c), 8'h00);
        sess = SS_STOP;
      end else begin
        push(EV_ERR, 32'hE1, 8'h00);
      end
    end
    drive_byte(c);
  endtask

  task automatic do_finish();
    if (sess == SS_BUSY) sess = SS_IDLE;
    else if (sess == SS_STOP) begin
      push(EV_STR, 32'd0, 8'h00);
      sess = SS_IDLE;
    end
    bus.finished = 1'b1;
    tick();
    bus.finished = 1'b0;
  endtask

  // Byte and finished together while a transaction is outstanding.
  task automatic do_fin_and_byte(input logic [7:0] b);
    push(EV_ERR, 32'hE1, 8'h00);
    if (sess == SS_STOP) push(EV_STR, 32'd0, 8'h00);
    sess = SS_IDLE;
    drive_byte(b, 1'b1);
  endtask

  // Address byte with no command byte following it.
  task automatic lone_addr(input logic [7:0] a);
    if (sess == SS_IDLE || sess == SS_STREAM) begin
      push(EV_ERR, 32'hE4, 8'h00);
      drive_byte(a);
      repeat (TO + 4) tick();
    end else begin
      push(EV_ERR, 32'hE1, 8'h00);
      drive_byte(a);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"},          32'(bus.enable),      32'd0);
    check({tag, "_device_selector"}, bus.device_selector,  32'd0);
    check({tag, "_request"},         32'(bus.request),     32'd0);
    check({tag, "_streaming"},       32'(bus.streaming),   32'd0);
    check({tag, "_error_valid"},     32'(bus.error_valid), 32'd0);
    check({tag, "_error_code"},      32'(bus.error_code),  32'd0);
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] a, c;
    int r;
    bus.rx_data  = 8'h00;
    bus.rx_done  = 1'b0;
    bus.finished = 1'b0;
    rst_n        = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Basic command with latency check, then back-to-back after finished
    do_pair(8'h00, 8'h01, 0);
    check("enable_n1", 32'(bus.enable), 32'd1);
    check("dev_n1", bus.device_selector, 32'h0000_0001);
    check("req_n1", 32'(bus.request), 32'h01);
    tick();
    check("enable_n2", 32'(bus.enable), 32'd0);
    repeat (18) tick();
    do_finish();
    do_pair(8'h00, 8'h02, 0);
    repeat (3) tick();
    do_finish();

    // Bad address leaves outputs untouched
    do_pair(8'h20, 8'h01, 2);
    tick();
    check("bad_addr_dev_hold", bus.device_selector, 32'h0000_0001);
    check("bad_addr_req_hold", 32'(bus.request), 32'h02);

    // Timeout, recovery, and a command exactly at the timeout limit
    lone_addr(8'h00);
    do_pair(8'h00, 8'h03, 1);
    tick();
    do_finish();
    do_pair(8'h01, 8'h04, TO);
    tick();
    do_finish();

    // Streaming session
    do_pair(8'h00, 8'h05, 0);
    check("stream_on", 32'(bus.streaming), 32'd1);
    do_pair(8'h00, 8'h01, 0);
    lone_addr(8'h00);
    do_finish();
    do_pair(8'h01, 8'h07, 0);
    do_pair(8'h00, 8'h07, 3);
    tick();
    check("stop_request", 32'(bus.request), 32'h07);
    check("stopping_streaming", 32'(bus.streaming), 32'd1);
    do_pair(8'h03, 8'h01, 0);
    do_finish();
    check("stream_off", 32'(bus.streaming), 32'd0);

    // Stop outside streaming
    do_pair(8'h00, 8'h08, 0);

    // Busy rejection, simultaneous finished and byte, forwarded unknown code
    do_pair(8'h02, 8'h01, 0);
    lone_addr(8'h05);
    do_fin_and_byte(8'h09);
    do_pair(8'h03, 8'h09, 0);

    // Reset while busy
    repeat (2) tick();
    check("pending_before_reset", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    exp_q.delete();
    sess = SS_IDLE;
    tick();
    mon_en = 1'b1;
    do_finish();
    do_pair(8'h04, 8'h02, 1);
    tick();
    do_finish();

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(32, 255));
        else if (sess == SS_STREAM && $urandom_range(0, 1) == 1) a = sa;
        else a = 8'($urandom_range(0, 31));
        if (sess == SS_STREAM && $urandom_range(0, 1) == 1) c = 8'($urandom_range(6, 9));
        else c = 8'($urandom_range(0, 12));
        do_pair(a, c, $urandom_range(0, 4));
      end else if (r < 75) begin
        do_finish();
      end else if (r < 85) begin
        if (sess == SS_BUSY || sess == SS_STOP) do_fin_and_byte(8'($urandom_range(0, 255)));
        else do_finish();
      end else if (r < 90) begin
        lone_addr(8'($urandom_range(0, 40)));
      end else begin
        repeat ($urandom_range(1, 5)) tick();
      end
    end

    repeat (5) tick();
    check("pending_at_end", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
